// File: rtl/memfill_engine_if.sv
// memfill_engine_if: bundles the control/status handshake and the memory
// write port of memfill_engine.
//   master modport : engine view (drives busy/done and the mem_* write request)
//   slave  modport : CPU / memory side view (drives start, run arguments, mem_ready)
// Optional feature macro: MEMFILL_ABORT_EN adds the abort request line.
interface memfill_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  word_count;
  logic [DATA_W-1:0] pattern;
  logic              mode;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
`ifdef MEMFILL_ABORT_EN
  logic              abort;
`endif

  modport master (
`ifdef MEMFILL_ABORT_EN
    input  abort,
`endif
    input  start, dst_addr, word_count, pattern, mode, mem_ready,
    output busy, done, mem_we, mem_addr, mem_wdata
  );

  modport slave (
`ifdef MEMFILL_ABORT_EN
    output abort,
`endif
    output start, dst_addr, word_count, pattern, mode, mem_ready,
    input  busy, done, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memfill_engine.sv
// memfill_engine: memset/fill engine. Writes word_count consecutive words
// starting at the word-aligned dst_addr, with either a constant pattern
// (mode=0) or a pattern incremented by one per word (mode=1).
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : memfill_engine_if.master (start/args in, busy/done out,
//            mem_we/mem_addr/mem_wdata out, mem_ready in)
// Optional feature macro: MEMFILL_ABORT_EN (abort input terminates a run in
// WRITE without committing the write presented in that cycle).
module memfill_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  memfill_engine_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(DATA_W / 8 - 1));

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [LEN_W-1:0]  r_remain;
  logic              r_mode;

  state_t            w_state_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [LEN_W-1:0]  w_remain_nxt;
  logic              w_mode_nxt;
  logic              w_abort;

`ifdef MEMFILL_ABORT_EN
  // Abort only matters while a write is being presented.
  assign w_abort = bus.abort && (r_state == ST_WRITE);
`else
  assign w_abort = 1'b0;
`endif

  // The write request is registered; abort masks it in the same cycle so
  // nothing is committed while the run is being cancelled.
  assign bus.mem_we    = r_mem_we & ~w_abort;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // Next-state and next-output logic; output registers track the next state.
  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_mem_addr;
    w_data_nxt   = r_mem_wdata;
    w_remain_nxt = r_remain;
    w_mode_nxt   = r_mode;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_addr_nxt   = bus.dst_addr & ALIGN_MASK;
          w_data_nxt   = bus.pattern;
          w_remain_nxt = bus.word_count;
          w_mode_nxt   = bus.mode;
          if (bus.word_count != {LEN_W{1'b0}}) begin
            w_state_nxt = ST_WRITE;
            w_we_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (w_abort) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else if (bus.mem_ready) begin
          // Write committed: advance; address and data wrap silently.
          w_addr_nxt   = r_mem_addr + STEP;
          w_data_nxt   = r_mem_wdata + DATA_W'(r_mode);
          w_remain_nxt = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_we_nxt   = 1'b1;
            w_busy_nxt = 1'b1;
          end
        end else begin
          // Stalled: hold the presented write unchanged.
          w_we_nxt   = 1'b1;
          w_busy_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_remain    <= {LEN_W{1'b0}};
      r_mode      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_data_nxt;
      r_remain    <= w_remain_nxt;
      r_mode      <= w_mode_nxt;
    end
  end

endmodule

// File: tb/tb_memfill_engine.sv
// tb_memfill_engine: directed self-checking bench for memfill_engine.
// A byte-wide memory model captures committed writes; expected values are
// hand-computed constants for each directed run.
module tb_memfill_engine;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;
  int n_commit = 0;
  int n_done   = 0;

  bit [7:0]    mem [0:511];
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  memfill_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  memfill_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: records every committed write.
  always @(posedge clk) begin
    if (rst_n && bus.mem_we && bus.mem_ready) begin
      for (int b = 0; b < 4; b++) begin
        mem[9'(bus.mem_addr + 32'(b))] <= bus.mem_wdata[8*b +: 8];
      end
      q_addr.push_back(bus.mem_addr);
      q_data.push_back(bus.mem_wdata);
      n_commit <= n_commit + 1;
    end
    if (rst_n && bus.done) begin
      n_done <= n_done + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] a, input logic [15:0] n,
                           input logic [31:0] p, input logic m);
    bus.start      = 1'b1;
    bus.dst_addr   = a;
    bus.word_count = n;
    bus.pattern    = p;
    bus.mode       = m;
  endtask

  int          c0;
  int          qb;
  int          d0;
  logic [31:0] pat;

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.dst_addr   = 32'h0;
    bus.word_count = 16'h0;
    bus.pattern    = 32'h0;
    bus.mode       = 1'b0;
    bus.mem_ready  = 1'b0;
`ifdef MEMFILL_ABORT_EN
    bus.abort      = 1'b0;
`endif
    #12;
    check_val("rst_busy", 64'(bus.busy), 64'h0);
    check_val("rst_done", 64'(bus.done), 64'h0);
    check_val("rst_we",   64'(bus.mem_we), 64'h0);
    check_val("rst_addr", 64'(bus.mem_addr), 64'h0);
    check_val("rst_data", 64'(bus.mem_wdata), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Constant fill of four words at 8.
    c0 = n_commit;
    bus.mem_ready = 1'b1;
    start_run(32'h8, 16'd4, 32'hDEADBEEF, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_val("t1_we",   64'(bus.mem_we), 64'h1);
      check_val("t1_busy", 64'(bus.busy), 64'h1);
      check_val("t1_addr", 64'(bus.mem_addr), 64'(32'h8 + 32'(4 * k)));
      check_val("t1_data", 64'(bus.mem_wdata), 64'hDEADBEEF);
      tick();
    end
    check_val("t1_done", 64'(bus.done), 64'h1);
    check_val("t1_busy_end", 64'(bus.busy), 64'h0);
    check_val("t1_we_end", 64'(bus.mem_we), 64'h0);
    tick();
    check_val("t1_done_pulse", 64'(bus.done), 64'h0);
    check_val("t1_commits", 64'(n_commit - c0), 64'd4);
    pat = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) begin
      check_val("t1_mem", 64'(mem[8 + i]), 64'(pat[8*(i%4) +: 8]));
    end
    check_val("t1_mem_after", 64'(mem[24]), 64'h0);

    // Incrementing fill with mem_ready toggling 1,0,1,0...
    c0 = n_commit;
    qb = q_addr.size();
    start_run(32'd28, 16'd4, 32'h00007FFF, 1'b1);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.mem_ready = (k % 2 == 0);
      check_val("t2_we",   64'(bus.mem_we), 64'h1);
      check_val("t2_addr", 64'(bus.mem_addr), 64'(32'd28 + 32'(4 * ((k + 1) / 2))));
      check_val("t2_data", 64'(bus.mem_wdata), 64'(32'h7FFF + 32'((k + 1) / 2)));
      tick();
    end
    check_val("t2_done", 64'(bus.done), 64'h1);
    bus.mem_ready = 1'b1;
    tick();
    check_val("t2_commits", 64'(n_commit - c0), 64'd4);
    if (q_addr.size() >= qb + 4) begin
      for (int i = 0; i < 4; i++) begin
        check_val("t2_q_addr", 64'(q_addr[qb + i]), 64'(32'd28 + 32'(4 * i)));
        check_val("t2_q_data", 64'(q_data[qb + i]), 64'(32'h7FFF + 32'(i)));
      end
    end

    // Zero count, then misaligned single word.
    c0 = n_commit;
    start_run(32'h0B, 16'd0, 32'h11111111, 1'b0);
    tick();
    bus.start = 1'b0;
    check_val("t3_we0",   64'(bus.mem_we), 64'h0);
    check_val("t3_done0", 64'(bus.done), 64'h1);
    check_val("t3_busy0", 64'(bus.busy), 64'h0);
    tick();
    check_val("t3_done0_pulse", 64'(bus.done), 64'h0);
    check_val("t3_commits0", 64'(n_commit - c0), 64'd0);
    start_run(32'h0B, 16'd1, 32'h12345678, 1'b0);
    tick();
    bus.start = 1'b0;
    check_val("t3_we1",   64'(bus.mem_we), 64'h1);
    check_val("t3_addr1", 64'(bus.mem_addr), 64'h8);
    check_val("t3_data1", 64'(bus.mem_wdata), 64'h12345678);
    tick();
    check_val("t3_done1", 64'(bus.done), 64'h1);
    tick();
    check_val("t3_commits1", 64'(n_commit - c0), 64'd1);

    // Address/data wrap; start during WRITE and DONE ignored.
    c0 = n_commit;
    qb = q_addr.size();
    start_run(32'hFFFFFFFC, 16'd2, 32'hFFFFFFFF, 1'b1);
    tick();
    start_run(32'h100, 16'd5, 32'h0, 1'b0);
    check_val("t4_addr0", 64'(bus.mem_addr), 64'hFFFFFFFC);
    check_val("t4_data0", 64'(bus.mem_wdata), 64'hFFFFFFFF);
    tick();
    bus.start = 1'b0;
    check_val("t4_we1",   64'(bus.mem_we), 64'h1);
    check_val("t4_addr1", 64'(bus.mem_addr), 64'h0);
    check_val("t4_data1", 64'(bus.mem_wdata), 64'h0);
    tick();
    check_val("t4_done", 64'(bus.done), 64'h1);
    start_run(32'h200, 16'd3, 32'h0, 1'b0);
    tick();
    bus.start = 1'b0;
    check_val("t4_idle_busy", 64'(bus.busy), 64'h0);
    check_val("t4_idle_we",   64'(bus.mem_we), 64'h0);
    check_val("t4_idle_done", 64'(bus.done), 64'h0);
    tick();
    check_val("t4_idle_we2", 64'(bus.mem_we), 64'h0);
    check_val("t4_commits", 64'(n_commit - c0), 64'd2);
    if (q_addr.size() >= qb + 2) begin
      check_val("t4_q_addr1", 64'(q_addr[qb + 1]), 64'h0);
      check_val("t4_q_data1", 64'(q_data[qb + 1]), 64'h0);
    end

    // Reset in the middle of a run.
    c0 = n_commit;
    start_run(32'h40, 16'd10, 32'h5, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check_val("t5_commits_pre", 64'(n_commit - c0), 64'd3);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_we",   64'(bus.mem_we), 64'h0);
    check_val("t5_rst_busy", 64'(bus.busy), 64'h0);
    check_val("t5_rst_addr", 64'(bus.mem_addr), 64'h0);
    check_val("t5_rst_data", 64'(bus.mem_wdata), 64'h0);
    check_val("t5_rst_done", 64'(bus.done), 64'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("t5_no_done", 64'(n_done - d0), 64'd0);
    check_val("t5_commits_post", 64'(n_commit - c0), 64'd3);
    start_run(32'h80, 16'd1, 32'hAA, 1'b0);
    tick();
    bus.start = 1'b0;
    check_val("t5_we",   64'(bus.mem_we), 64'h1);
    check_val("t5_addr", 64'(bus.mem_addr), 64'h80);
    check_val("t5_data", 64'(bus.mem_wdata), 64'hAA);
    tick();
    check_val("t5_done", 64'(bus.done), 64'h1);
    tick();

`ifdef MEMFILL_ABORT_EN
    // Abort on the third WRITE cycle.
    c0 = n_commit;
    start_run(32'h100, 16'd8, 32'h1, 1'b1);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.abort = 1'b1;
    #1;
    check_val("t6_we_masked", 64'(bus.mem_we), 64'h0);
    tick();
    bus.abort = 1'b0;
    check_val("t6_done", 64'(bus.done), 64'h1);
    check_val("t6_busy", 64'(bus.busy), 64'h0);
    check_val("t6_commits", 64'(n_commit - c0), 64'd2);
    tick();
    check_val("t6_done_pulse", 64'(bus.done), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/memfill_engine.md
Name: memfill_engine

Overview:
Hardware memset/fill engine that writes a programmable pattern to a run of consecutive data-memory words, offloading software fill loops from the CPU. Sits beside the data memory as a write master on the dmemory write port; the CPU starts it with a one-cycle pulse and polls busy/done. Generalised over data width, address width, length width and fill mode (constant or incrementing pattern).

Parameters:
ADDR_W, 32, byte-address width of the memory port
DATA_W, 32, word width in bits; power of two, >= 8; address step = DATA_W/8 bytes
LEN_W, 16, width of word_count; max run = 2^LEN_W-1 words

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; sampled only in IDLE
dst_addr  input  ADDR_W  byte start address; low log2(DATA_W/8) bits ignored (forced 0)
word_count  input  LEN_W  number of words to write
pattern  input  DATA_W  first word value
mode  input  1  0 = constant fill, 1 = pattern increments by 1 per word
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse when run completes
mem_we  output  1  write request
mem_addr  output  ADDR_W  word-aligned byte address
mem_wdata  output  DATA_W  write data
mem_ready  input  1  memory accepts write this cycle (mem_we && mem_ready = write committed)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0; internal counters 0.
- States: IDLE, WRITE, DONE.
- IDLE: start=1 latches aligned dst_addr, word_count, pattern, mode. Count>0 -> WRITE; count=0 -> DONE (no writes).
- WRITE: mem_we=1, mem_addr=current address, mem_wdata=current value. On mem_we&&mem_ready: address += DATA_W/8 (mod 2^ADDR_W, wraps silently), value += mode (mod 2^DATA_W), remaining -= 1; if remaining was 1 -> DONE. mem_ready=0: hold all outputs stable (no advance).
- DONE: done=1 for exactly one cycle, mem_we=0, busy=0; -> IDLE.
- busy=1 in WRITE only; first write presented the cycle after start (latency 1); N words with mem_ready tied high take N cycles in WRITE, done on cycle N+1 after start.
- start while not IDLE: ignored, no effect on current run.
- start in the DONE cycle: ignored; accepted next cycle in IDLE.
- rst_n low mid-run: immediate return to reset values; partially written memory stays as is; no done pulse.
- Increment wrap: value FFFF_FFFF + 1 -> 0000_0000 (DATA_W=32).

Optional Feature:
MEMFILL_ABORT_EN: adds input port abort (1 bit). When defined: abort=1 in WRITE drops mem_we that same cycle (no write committed even if mem_ready=1), moves to DONE, done pulses once; abort outside WRITE ignored. When not defined: port absent; runs always complete all words.

Test Plan:
- Constant fill: dst_addr=8, word_count=4, pattern=DEADBEEF, mode=0, mem_ready=1 -> writes at 8,12,16,20 all DEADBEEF on cycles 1-4; done pulse cycle 5; bytes 8..23 read ef,be,ad,de repeated; byte 24 untouched (00).
- Incrementing fill with stalls: dst_addr=28, count=4, pattern=00007FFF, mode=1, mem_ready toggling 1,0,1,0... -> data 7FFF,8000,8001,8002 at 28,32,36,40; outputs stable during each mem_ready=0 cycle; exactly 4 commits.
- Zero count and misalignment: dst_addr=0x0B, count=0 -> no mem_we, done one cycle after start; then count=1 -> single write at address 0x08.
- Wrap and ignored start: dst_addr=FFFF_FFFC, count=2, pattern=FFFF_FFFF, mode=1 -> writes FFFF_FFFF@FFFF_FFFC then 0@0; start pulsed mid-run with other args has no effect.
- Reset mid-run: count=10, deassert rst_n after 3 commits -> outputs at reset values asynchronously, no done; next start runs normally.
- (MEMFILL_ABORT_EN) count=8, abort on 3rd WRITE cycle with mem_ready=1 -> exactly 2 writes committed, done pulse next cycle, busy drops.
